serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial multi-bit adder that drives the team's one-bit full adder `fa` one bit per clock.
- Parallel operands are loaded on a start pulse and shifted LSB-first through a single `fa` instance, with the carry held in a flop between bits.
- Produces a WIDTH-bit sum and a carry-out with a done pulse.
- Trades latency for area versus a ripple-carry chain.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range is WIDTH >= 2.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin an addition; sampled on the rising edge.
- a  input  WIDTH  operand A; captured only when start is accepted.
- b  input  WIDTH  operand B; captured only when start is accepted.
- cin  input  1  carry-in; captured only when start is accepted.
- busy  output  1  high while the block is in SHIFT.
- done  output  1  one-cycle pulse; sum and cout are valid.
- sum  output  WIDTH  registered result; held until the next result.
- cout  output  1  registered carry-out; held until the next result.

Behaviour:
- Reset:
  - rst high at an edge forces state=IDLE and clears the operand regs, carry flop and bit counter.
  - Outputs: busy=0, done=0, sum=0, cout=0.
  - rst has priority over every other input, including mid-operation; any in-flight addition is discarded with no done pulse.
- States: IDLE, SHIFT, DONE.
- Start acceptance:
  - In IDLE or DONE, start=1 at an edge loads a_reg<=a, b_reg<=b, carry<=cin, cnt<=0 and sets state<=SHIFT.
- SHIFT (busy=1), at each edge:
  - The fa slice takes a_reg[0], b_reg[0] and carry, and produces s and c.
  - res_reg <= {s, res_reg[WIDTH-1:1]}; a_reg and b_reg shift right by 1; carry <= c; cnt <= cnt+1.
  - When cnt==WIDTH-1: sum <= {s, res_reg[WIDTH-1:1]}, cout <= c, state <= DONE.
- DONE:
  - done=1 for exactly one cycle; busy=0.
  - Next state is SHIFT if start=1 (new operands loaded), otherwise IDLE.
- Latency:
  - With start accepted at edge k, sum and cout update at edge k+WIDTH.
  - done is high during the cycle after edge k+WIDTH.
  - Throughput is one addition per WIDTH+1 cycles; the back-to-back start in DONE achieves this.
- start while busy=1 is ignored; operands are not recaptured and the current addition is not disturbed.
- a, b and cin are don't-care outside the start-acceptance edge.
- sum and cout change only at the final SHIFT edge or on reset; partial results are never visible on sum.
- Arithmetic: {cout,sum} == a + b + cin for all values, modulo 2^(WIDTH+1), with no overflow flag.
- cnt width is clog2(WIDTH) bits minimum; the terminal-count compare is against WIDTH-1 only.
- rst and start high together: reset wins, and state is IDLE after the edge.

Test Plan:
- Basic add: WIDTH=8, a=0x5A, b=0x3C, cin=0, start for 1 cycle -> done high exactly 8 cycles after the start edge, sum=0x96, cout=0; busy high for 8 cycles.
- Carry-ripple corners:
  - a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1.
  - a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
  - a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0.
- Start while busy: start a=0x10, b=0x20; re-assert start with a=0xAA, b=0x55 at cycle 3 -> single done, sum=0x30, cout=0, and no second result.
- Back-to-back: hold start=1 during the DONE cycle with new a=0x80, b=0x80, cin=0 -> first result is held; the second done arrives 8 cycles later with sum=0x00, cout=1 and no IDLE cycle between.
- Reset mid-operation: assert rst at cycle 4 of SHIFT -> next cycle busy=0, done=0, sum=0, cout=0; no done ever for the aborted add; a following start gives a correct result.
- Randomized self-check: 1000 random a, b, cin with random idle gaps -> every done satisfies {cout,sum}==a+b+cin, and done is never high for 2 consecutive cycles unless separated by SHIFT.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice, LSB first, carry kept in a flop.
// A WIDTH-bit add takes WIDTH shift cycles plus one done cycle.

module fa (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    // Single-bit full adder slice
    always_comb begin
        s_o = a_i ^ b_i ^ c_i;
        c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
    end

endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-2:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic             fa_s;
    logic             fa_c;
    logic             load;
    logic             last;
    logic [WIDTH-1:0] res_ext;

    fa u_fa (
        .a_i(a_q[0]),
        .b_i(b_q[0]),
        .c_i(carry_q),
        .s_o(fa_s),
        .c_o(fa_c)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start in DONE chains straight into a new add
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (last) state_d = DONE;
            DONE:    state_d = start ? SHIFT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status outputs decoded from state
    always_comb begin
        busy = (state_q == SHIFT);
        done = (state_q == DONE);
    end

    // Datapath next-state: load operands, or shift one bit per cycle
    always_comb begin
        load    = start && ((state_q == IDLE) || (state_q == DONE));
        last    = (cnt_q == LAST);
        res_ext = {fa_s, res_q};
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        if (load) begin
            a_d     = a;
            b_d     = b;
            carry_d = cin;
            cnt_d   = '0;
        end else if (state_q == SHIFT) begin
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            carry_d = fa_c;
            cnt_d   = cnt_q + 1'b1;
            res_d   = res_ext[WIDTH-1:1];
            if (last) begin
                sum_d  = res_ext;
                cout_d = fa_c;
            end
        end
    end

    // Datapath registers; sum/cout only move on the final shift
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: directed corners then random adds.
// Expected {cout,sum} comes from plain integer addition.

module tb_serial_adder;

    localparam int W = 8;

    typedef struct {
        logic [W:0] val;
        int         cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int   cyc = 0;
    bit   rst_q = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t sbq[$];

    serial_adder #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    task automatic chk(input string nm, input logic [W:0] act,
                       input logic [W:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h",
                     nm, cyc, act, exp);
        end
    endtask

    task automatic idle(input int n);
        start = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Issue one add; poke re-asserts start mid-shift, abort resets mid-shift.
    // Returns #1 after the edge that enters DONE (or after the reset edge).
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic cv, input int poke, input int abort);
        exp_t e;
        a       = av;
        b       = bv;
        cin     = cv;
        start   = 1'b1;
        e.val   = (W+1)'(av) + (W+1)'(bv) + (W+1)'(cv);
        e.cyc   = cyc + 1 + W;
        if (abort < 0) sbq.push_back(e);
        for (int i = 0; i < W; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            a     = W'($urandom);
            b     = W'($urandom);
            cin   = 1'($urandom);
            chk("busy_shift", (W+1)'(busy), 1);
            chk("done_in_shift", (W+1)'(done), 0);
            if (i == poke) start = 1'b1;
            if (i == abort) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                chk("rst_busy", (W+1)'(busy), 0);
                chk("rst_done", (W+1)'(done), 0);
                chk("rst_result", {cout, sum}, 0);
                return;
            end
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_in_done", (W+1)'(busy), 0);
        chk("done_pulse", (W+1)'(done), 1);
    endtask

    // Monitor: pops on every done, checks value, timing and held result
    initial begin : monitor
        exp_t       e;
        logic [W:0] hold;
        hold = '0;
        forever begin
            @(negedge clk);
            if (rst_q) hold = '0;
            if (done) begin
                if (sbq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_done at cycle %0d: got %h expected none",
                             cyc, {cout, sum});
                end else begin
                    e = sbq.pop_front();
                    chk("result", {cout, sum}, e.val);
                    chk("latency", (W+1)'(cyc), (W+1)'(e.cyc));
                    hold = e.val;
                end
            end
            if (sbq.size() > 0) begin
                n_chk++;
                if (cyc > sbq[0].cyc) begin
                    n_fail++;
                    $display("FAIL missing_done at cycle %0d: got none expected %h",
                             cyc, sbq[0].val);
                    void'(sbq.pop_front());
                end
            end
            chk("held_result", {cout, sum}, hold);
        end
    end

    initial begin : stim
        int gap;
        int poke;
        rst   = 1'b1;
        start = 1'b1;
        a     = W'($urandom);
        b     = W'($urandom);
        cin   = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("reset_busy", (W+1)'(busy), 0);
        chk("reset_done", (W+1)'(done), 0);
        chk("reset_result", {cout, sum}, 0);
        rst   = 1'b0;
        start = 1'b0;
        idle(2);
        chk("idle_busy", (W+1)'(busy), 0);

        run_op(8'h5A, 8'h3C, 1'b0, -1, -1);
        idle(2);
        run_op(8'hFF, 8'h01, 1'b0, -1, -1);
        idle(1);
        run_op(8'hFF, 8'hFF, 1'b1, -1, -1);
        idle(1);
        run_op(8'h00, 8'h00, 1'b1, -1, -1);
        idle(2);
        run_op(8'h10, 8'h20, 1'b0, 2, -1);
        idle(12);
        run_op(8'h33, 8'h44, 1'b1, -1, -1);
        run_op(8'h80, 8'h80, 1'b0, -1, -1);
        idle(2);
        run_op(8'hC3, 8'h5E, 1'b1, -1, 3);
        chk("abort_flushed", (W+1)'(sbq.size()), 0);
        idle(12);
        run_op(8'h12, 8'h34, 1'b1, -1, -1);
        idle(1);

        for (int n = 0; n < 1000; n++) begin
            gap  = $urandom_range(0, 3);
            poke = ($urandom_range(0, 3) == 0) ? $urandom_range(0, W - 1) : -1;
            if (gap > 0) idle(gap);
            run_op(W'($urandom), W'($urandom), 1'($urandom), poke, -1);
        end

        idle(W + 4);
        chk("scoreboard_empty", (W+1)'(sbq.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
